// File: rtl/single_macc_frac_decim.sv
// Fractional-rate polyphase FIR resampler (L/M) built around one time-shared
// signed 18x18 multiply-accumulate unit with run-time loadable coefficients.
module single_macc_frac_decim #(
  parameter int InterpolationK = 2,
  parameter int DecimationK    = 3,
  parameter int TapsPerPhase   = 8,
  parameter int CoeffAddrW     = 4
) (
  input  logic                  Clk_i,
  input  logic                  Rst_i,
  input  logic [CoeffAddrW-1:0] CoeffAddr_i,
  input  logic signed [17:0]    CoeffData_i,
  input  logic                  CoeffWr_i,
  input  logic signed [17:0]    Data_i,
  input  logic                  DataNd_i,
  output logic signed [17:0]    Data_o,
  output logic                  DataValid_o
);

  localparam int PhW  = $clog2(InterpolationK + DecimationK + 1);
  localparam int CntW = $clog2(TapsPerPhase + 3);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StCompute = 1'b1;

  localparam logic [PhW-1:0]  PhL        = PhW'(InterpolationK);
  localparam logic [PhW-1:0]  PhM        = PhW'(DecimationK);
  localparam logic [CntW-1:0] CntLastMac = CntW'(TapsPerPhase - 1);
  localparam logic [CntW-1:0] CntAccEnd  = CntW'(TapsPerPhase);
  localparam logic [CntW-1:0] CntSat     = CntW'(TapsPerPhase + 1);
  localparam logic [CntW-1:0] CntOut     = CntW'(TapsPerPhase + 2);

  logic signed [17:0] coef [2**CoeffAddrW];
  logic signed [17:0] dly  [TapsPerPhase];

  logic [0:0]            state;
  logic [PhW-1:0]        ph, phDec, phInc;
  logic [CntW-1:0]       cnt;
  logic [CoeffAddrW-1:0] rdAddr;
  logic signed [17:0]    tapX, tapH, satVal, satNext;
  logic signed [35:0]    prod;
  logic signed [38:0]    acc;
  logic signed [21:0]    accSh;

  // Coefficient storage is deliberately outside the reset domain.
  always_ff @(posedge Clk_i) begin
    if (CoeffWr_i) coef[CoeffAddr_i] <= CoeffData_i;
  end

  always_comb begin
    tapX = '0;
    for (int unsigned i = 0; i < TapsPerPhase; i++) begin
      if (cnt == CntW'(i)) tapX = dly[i];
    end
    rdAddr = CoeffAddrW'(int'(ph) + InterpolationK * int'(cnt));
    tapH   = coef[rdAddr];
  end

  always_comb begin
    accSh = acc[38:17];
    if (accSh > 22'sd131071)       satNext = 18'sh1FFFF;
    else if (accSh < -22'sd131072) satNext = 18'sh20000;
    else                           satNext = accSh[17:0];
  end

  assign phDec = ph - PhL;
  assign phInc = ph + PhM;

  // cnt 0..T-1 registers products, 1..T accumulates them, T+1 saturates,
  // T+2 publishes; this lands the valid pulse T+3 cycles after acceptance.
  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      state       <= StIdle;
      ph          <= PhL;
      cnt         <= '0;
      prod        <= '0;
      acc         <= '0;
      satVal      <= '0;
      Data_o      <= '0;
      DataValid_o <= 1'b0;
      for (int unsigned i = 0; i < TapsPerPhase; i++) dly[i] <= '0;
    end else begin
      DataValid_o <= 1'b0;
      case (state)
        StIdle: begin
          if (DataNd_i) begin
            dly[0] <= Data_i;
            for (int unsigned i = 1; i < TapsPerPhase; i++) dly[i] <= dly[i-1];
            ph <= phDec;
            if (phDec < PhL) begin
              state <= StCompute;
              cnt   <= '0;
              acc   <= '0;
            end
          end
        end
        default: begin
          cnt <= cnt + CntW'(1);
          if (cnt <= CntLastMac) prod <= tapX * tapH;
          if (cnt != '0 && cnt <= CntAccEnd) acc <= acc + 39'(prod);
          if (cnt == CntSat) satVal <= satNext;
          if (cnt == CntOut) begin
            Data_o      <= satVal;
            DataValid_o <= 1'b1;
            ph          <= phInc;
            cnt         <= '0;
            acc         <= '0;
            if (phInc >= PhL) state <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_single_macc_frac_decim.sv
// Randomized bench for single_macc_frac_decim against an arithmetic
// reference model of the L/M polyphase resampler.
module tb_single_macc_frac_decim;

  localparam int L  = 2;
  localparam int M  = 3;
  localparam int T  = 8;
  localparam int AW = 4;
  localparam int NCoef = 2**AW;

  logic          Clk_i = 1'b0;
  logic          Rst_i;
  logic [AW-1:0] CoeffAddr_i;
  logic [17:0]   CoeffData_i;
  logic          CoeffWr_i;
  logic [17:0]   Data_i;
  logic          DataNd_i;
  logic [17:0]   Data_o;
  logic          DataValid_o;

  int checks   = 0;
  int failures = 0;

  int          mdlH [NCoef];
  int          mdlX [T];
  int          mdlPh;
  logic [17:0] lastOut;
  int          validCnt;

  single_macc_frac_decim #(
    .InterpolationK(L),
    .DecimationK   (M),
    .TapsPerPhase  (T),
    .CoeffAddrW    (AW)
  ) dut (
    .Clk_i      (Clk_i),
    .Rst_i      (Rst_i),
    .CoeffAddr_i(CoeffAddr_i),
    .CoeffData_i(CoeffData_i),
    .CoeffWr_i  (CoeffWr_i),
    .Data_i     (Data_i),
    .DataNd_i   (DataNd_i),
    .Data_o     (Data_o),
    .DataValid_o(DataValid_o)
  );

  always #5 Clk_i = ~Clk_i;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] refOut(int p);
    longint s;
    longint q;
    s = 0;
    for (int j = 0; j < T; j++) s += longint'(mdlX[j]) * longint'(mdlH[p + L*j]);
    q = s >>> 17;
    if (q > 131071) q = 131071;
    else if (q < -131072) q = -131072;
    return q[17:0];
  endfunction

  function automatic void mdlReset();
    for (int j = 0; j < T; j++) mdlX[j] = 0;
    mdlPh   = L;
    lastOut = '0;
  endfunction

  task automatic writeCoef(input int addr, input logic [17:0] val);
    @(negedge Clk_i);
    CoeffAddr_i = AW'(addr);
    CoeffData_i = val;
    CoeffWr_i   = 1'b1;
    @(negedge Clk_i);
    CoeffWr_i   = 1'b0;
    mdlH[addr]  = int'(signed'(val));
  endtask

  // Model one accepted sample; returns whether it yields an output and its value.
  task automatic mdlAccept(input logic [17:0] x, output bit expV, output logic [17:0] expD);
    for (int j = T-1; j > 0; j--) mdlX[j] = mdlX[j-1];
    mdlX[0] = int'(signed'(x));
    mdlPh  -= L;
    expV = 1'b0;
    expD = lastOut;
    if (mdlPh < L) begin
      expV = 1'b1;
      expD = refOut(mdlPh);
      mdlPh += M;
    end
  endtask

  task automatic sendSample(input logic [17:0] x, input bit extra);
    bit          expV;
    logic [17:0] expD;
    mdlAccept(x, expV, expD);
    @(negedge Clk_i);
    Data_i   = x;
    DataNd_i = 1'b1;
    @(posedge Clk_i);
    #1;
    DataNd_i = 1'b0;
    Data_i   = 18'($urandom);
    for (int k = 1; k < 16; k++) begin
      @(posedge Clk_i);
      #1;
      if (DataValid_o) validCnt++;
      checkVal("valid", 64'(DataValid_o), 64'(expV && k == T+3));
      if (expV && k == T+3) begin
        checkVal("dataOut", 64'(Data_o), 64'(expD));
        lastOut = expD;
      end else begin
        checkVal("dataHold", 64'(Data_o), 64'(lastOut));
      end
      if (extra && expV && k == 2) begin
        DataNd_i = 1'b1;
        Data_i   = 18'($urandom);
      end
      if (k == 3) DataNd_i = 1'b0;
    end
  endtask

  task automatic idleCheck(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk_i);
      #1;
      checkVal("idleValid", 64'(DataValid_o), 64'(0));
      checkVal("idleData", 64'(Data_o), 64'(lastOut));
    end
  endtask

  initial begin
    Rst_i       = 1'b0;
    CoeffAddr_i = '0;
    CoeffData_i = '0;
    CoeffWr_i   = 1'b0;
    Data_i      = '0;
    DataNd_i    = 1'b0;
    validCnt    = 0;
    mdlReset();

    repeat (2) @(posedge Clk_i);
    #1;
    checkVal("rstData", 64'(Data_o), 64'(0));
    checkVal("rstValid", 64'(DataValid_o), 64'(0));
    for (int a = 0; a < NCoef; a++) writeCoef(a, 18'($urandom));
    @(negedge Clk_i);
    Rst_i = 1'b1;
    idleCheck(20);

    // Zero input stream: 9 inputs from reset give 6 outputs, all zero.
    validCnt = 0;
    for (int n = 0; n < 9; n++) sendSample('0, 1'b0);
    checkVal("rateCount", 64'(validCnt), 64'(6));

    for (int a = 0; a < NCoef; a++) writeCoef(a, (a < 2) ? 18'h10000 : 18'h0);
    for (int n = 0; n < 6; n++) sendSample(18'h1FFFF, 1'b0);

    for (int a = 0; a < NCoef; a++) writeCoef(a, 18'h02000);
    sendSample('0, 1'b0);
    for (int n = 0; n < 12; n++) sendSample(18'h1FFFF, 1'b0);

    for (int a = 0; a < NCoef; a++) writeCoef(a, 18'h1FFFF);
    for (int n = 0; n < 6; n++) sendSample(18'h1FFFF, 1'b0);
    for (int n = 0; n < 6; n++) sendSample(18'h20000, 1'b0);

    for (int a = 0; a < NCoef; a++) writeCoef(a, 18'($urandom));
    for (int n = 0; n < 30; n++) sendSample(18'($urandom), 1'($urandom_range(0, 1)));

    // Abort a computation with an asynchronous reset partway through.
    while (mdlPh - L >= L) sendSample(18'($urandom), 1'b0);
    @(negedge Clk_i);
    Data_i   = 18'($urandom);
    DataNd_i = 1'b1;
    @(posedge Clk_i);
    #1;
    DataNd_i = 1'b0;
    repeat (4) @(posedge Clk_i);
    #3;
    Rst_i = 1'b0;
    #1;
    checkVal("asyncRstData", 64'(Data_o), 64'(0));
    checkVal("asyncRstValid", 64'(DataValid_o), 64'(0));
    mdlReset();
    repeat (2) @(negedge Clk_i);
    Rst_i = 1'b1;
    idleCheck(16);
    for (int n = 0; n < 6; n++) sendSample(18'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
